div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage, beside the combinational ALU.
- Executes DIV/DIVU/REM/REMU over multiple cycles so the single-cycle ALU divide path can be removed from the critical path.
- Uses the same 5-bit SELECT (ALUOP) encoding as the ALU.
- BUSY drives the hazard unit as an EX stall; the registered RESULT feeds the EX/MEM register on DONE.

Parameters:
- XLEN, 32, operand/result width; iteration count = XLEN.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request, sampled only in IDLE.
- SELECT  input  5  ALUOP: 01111 DIV, 10000 DIVU, 10001 REM, 10010 REMU.
- DATA1  input  XLEN  dividend.
- DATA2  input  XLEN  divisor.
- FLUSH  input  1  synchronous abort from branch/hazard unit.
- BUSY  output  1  operation in progress; EX stall request.
- DONE  output  1  one-cycle pulse, RESULT valid.
- RESULT  output  XLEN  quotient or remainder, held until the next completion.

Behaviour:
- Reset (RESET=0, async): state=IDLE, BUSY=0, DONE=0, RESULT=0, counter/internal registers cleared. This applies immediately, including mid-operation.
- States: IDLE, CALC, FIN.
- IDLE:
  - START=1 with SELECT in {01111,10000,10001,10010} at edge E0 accepts the request.
  - On accept, latch the op, operand magnitudes and sign flags:
    - Signed ops: magnitude = two's-complement abs; 0x80000000 stays 0x80000000 as unsigned.
    - Unsigned ops: operands taken as-is.
  - Next state = CALC, counter = XLEN-1, remainder accumulator = 0.
  - If DATA2==0, next state = FIN and CALC is skipped.
  - START with any other SELECT is ignored; no state change.
- CALC: per edge:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude; if non-negative, keep the difference and set quo[0]=1.
  - Decrement counter. The iteration at counter=0 is the last; next state = FIN.
  - Exactly XLEN iterations (edges E1..E32 for XLEN=32).
- FIN: at the next edge:
  - Sign-correct and register RESULT, assert DONE for one cycle, return to IDLE.
  - DIV: quotient negated if sign1^sign2.
  - REM: remainder negated if sign1.
  - DIVU/REMU: no correction.
- BUSY=1 in CALC and FIN, 0 in IDLE.
- DONE=1 only in the cycle after the FIN edge; BUSY is already 0 in that cycle.
- Latency, nonzero divisor: DONE is high in the cycle after E33 (33 edges after the accepting edge). Zero divisor: DONE after E1.
- A new START may be sampled in the same cycle DONE is high (back-to-back operations).
- START while BUSY: ignored.
- FLUSH=1 at an edge:
  - state→IDLE, BUSY→0, no DONE, RESULT unchanged.
  - FLUSH and START together in IDLE: FLUSH wins, request not accepted.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM gives 0. This falls out of the magnitude algorithm; no special case is needed.
- Divide-by-zero without the macro: RESULT=0 for all four ops, matching the ALU.

Optional Feature:
- Macro: DIV_RISCV_DIVZERO_EN.
- Defined: divide-by-zero follows the RISC-V spec. DIV/DIVU → all ones (0xFFFFFFFF); REM/REMU → DATA1 as latched at START. Latency is still the FIN path (DONE after E1).
- Undefined: divide-by-zero gives RESULT=0 for all ops. No extra storage for the zero-divisor dividend is built.

Test Plan:
- DIVU DATA1=100, DATA2=7, START at E0 → BUSY=1 from E0; DONE in cycle after E33; RESULT=14. REMU on same operands → 2.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3). REM → 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE → 0xFFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM on same operands → 0x00000000. No hang, normal 33-edge latency.
- DIVU 5/0 → DONE after E1, RESULT=0 (0xFFFFFFFF with DIV_RISCV_DIVZERO_EN). REMU 5/0 → 0 (5 with macro).
- DIV in progress, FLUSH at E10 → BUSY=0 next cycle, DONE never asserted, RESULT keeps prior value. Then DIVU 9/3 → RESULT=3 after 33 edges.
- RESET low at E15 of an operation → BUSY/DONE/RESULT=0 immediately, without a clock edge. START pulses during BUSY and START with SELECT=00001 (ADD) in IDLE → ignored, BUSY stays as-is.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Build option DIV_RISCV_DIVZERO_EN selects RISC-V divide-by-zero results instead of zero.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [4:0]      select,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [1:0]      dbg_state
);

   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_DIVU = 5'b10000;
   localparam logic [4:0] OP_REM  = 5'b10001;
   localparam logic [4:0] OP_REMU = 5'b10010;

   // Handshake: start is a request sampled only while idle (busy=0); done is a
   // one-cycle valid strobe for result, which then holds until the next completion.

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] div_mag;
   logic            sign1;
   logic            sign2;
   logic            op_rem;
   logic            op_signed;
   logic            divzero;

   logic            sel_valid;
   logic            sel_signed;
   logic            sel_rem;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   diff;
   logic [XLEN-1:0] fin_result;

   always_comb begin
      sel_valid  = (select == OP_DIV) || (select == OP_DIVU) ||
                   (select == OP_REM) || (select == OP_REMU);
      sel_signed = (select == OP_DIV) || (select == OP_REM);
      sel_rem    = (select == OP_REM) || (select == OP_REMU);
      a_neg      = sel_signed & data1[XLEN-1];
      b_neg      = sel_signed & data2[XLEN-1];
      a_mag      = a_neg ? -data1 : data1;
      b_mag      = b_neg ? -data2 : data2;
   end

   // Remainder is always below the divisor, so the shifted value fits in XLEN+1 bits.
   always_comb begin
      rem_sh = {rem, quo[XLEN-1]};
      diff   = rem_sh - {1'b0, div_mag};
   end

   always_comb begin
      fin_result = '0;
      if (divzero) begin
`ifdef DIV_RISCV_DIVZERO_EN
         fin_result = op_rem ? quo : '1;
`else
         fin_result = '0;
`endif
      end else if (op_rem) begin
         fin_result = (op_signed && sign1) ? -rem : rem;
      end else begin
         fin_result = (op_signed && (sign1 ^ sign2)) ? -quo : quo;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         div_mag   <= '0;
         sign1     <= 1'b0;
         sign2     <= 1'b0;
         op_rem    <= 1'b0;
         op_signed <= 1'b0;
         divzero   <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start && sel_valid) begin
                     sign1     <= a_neg;
                     sign2     <= b_neg;
                     op_rem    <= sel_rem;
                     op_signed <= sel_signed;
                     div_mag   <= b_mag;
                     rem       <= '0;
                     cnt       <= CW'(XLEN - 1);
                     divzero   <= (data2 == '0);
`ifdef DIV_RISCV_DIVZERO_EN
                     // With a zero divisor CALC is skipped, so quo can carry the raw dividend.
                     quo       <= (data2 == '0) ? data1 : a_mag;
`else
                     quo       <= a_mag;
`endif
                     state     <= (data2 == '0) ? FIN : CALC;
                  end
               end
               CALC: begin
                  if (!diff[XLEN]) begin
                     rem <= diff[XLEN-1:0];
                     quo <= {quo[XLEN-2:0], 1'b1};
                  end else begin
                     rem <= rem_sh[XLEN-1:0];
                     quo <= {quo[XLEN-2:0], 1'b0};
                  end
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) state <= FIN;
               end
               FIN: begin
                  result <= fin_result;
                  done   <= 1'b1;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner sequences,
// and random operations compared against a plain-arithmetic reference model.
module tb_div_unit;

   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_DIVU = 5'b10000;
   localparam logic [4:0] OP_REM  = 5'b10001;
   localparam logic [4:0] OP_REMU = 5'b10010;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  select;
   logic [31:0] data1;
   logic [31:0] data2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;
   int e0_cyc  = 0;
   logic [31:0] last_res = '0;
   logic [31:0] exp_q[$];
   int          lat_q[$];

   typedef struct {
      string       name;
      logic [4:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   div_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .select(select),
      .data1(data1), .data2(data2), .flush(flush),
      .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: plain signed/unsigned arithmetic on 64-bit values.
   function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      bit is_signed, is_rem;
      is_signed = (sel == OP_DIV) || (sel == OP_REM);
      is_rem    = (sel == OP_REM) || (sel == OP_REMU);
      if (b == 0) begin
`ifdef DIV_RISCV_DIVZERO_EN
         return is_rem ? a : 32'hFFFF_FFFF;
`else
         return 32'h0;
`endif
      end
      sa = is_signed ? longint'($signed(a)) : longint'({32'h0, a});
      sb = is_signed ? longint'($signed(b)) : longint'({32'h0, b});
      q  = sa / sb;
      r  = sa % sb;
      return is_rem ? r[31:0] : q[31:0];
   endfunction

   // driver: present a request and hold it for one edge (the accepting edge E0)
   task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      select = sel;
      data1  = a;
      data2  = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
      e0_cyc = cyc_cnt;
   endtask

   task automatic start_op(input string name, input logic [4:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
      exp_q.push_back(exp);
      lat_q.push_back((b == 0) ? 1 : 33);
      issue(sel, a, b);
      check({name, "_busy_after_accept"}, 32'(busy), 32'd1);
   endtask

   // scoreboard: wait (bounded) for done, compare result and latency with the queue head
   task automatic wait_done(input string name);
      logic [31:0] exp;
      int exp_lat;
      bit seen;
      exp     = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      seen    = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (done) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: done not seen within 100 cycles", name);
      end else begin
         check({name, "_result"}, result, exp);
         check({name, "_latency"}, 32'(cyc_cnt - e0_cyc), 32'(exp_lat));
         check({name, "_busy_at_done"}, 32'(busy), 32'd0);
         last_res = exp;
      end
   endtask

   initial begin
      bit saw_done;
      reset  = 1'b0;
      start  = 1'b0;
      select = '0;
      data1  = '0;
      data2  = '0;
      flush  = 1'b0;

      vecs[0]  = '{"divu_100_7",  OP_DIVU, 32'd100,        32'd7,          32'd14};
      vecs[1]  = '{"remu_100_7",  OP_REMU, 32'd100,        32'd7,          32'd2};
      vecs[2]  = '{"div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
      vecs[3]  = '{"rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
      vecs[4]  = '{"div_7_m2",    OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
      vecs[5]  = '{"div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
      vecs[6]  = '{"rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0};
      vecs[7]  = '{"divu_max_1",  OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
`ifdef DIV_RISCV_DIVZERO_EN
      vecs[8]  = '{"divu_5_0",    OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
      vecs[9]  = '{"remu_5_0",    OP_REMU, 32'd5,          32'd0,          32'd5};
      vecs[10] = '{"div_m7_0",    OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF};
      vecs[11] = '{"rem_m7_0",    OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
`else
      vecs[8]  = '{"divu_5_0",    OP_DIVU, 32'd5,          32'd0,          32'd0};
      vecs[9]  = '{"remu_5_0",    OP_REMU, 32'd5,          32'd0,          32'd0};
      vecs[10] = '{"div_m7_0",    OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'd0};
      vecs[11] = '{"rem_m7_0",    OP_REM,  32'hFFFF_FFF9,  32'd0,          32'd0};
`endif

      #22;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_busy",   32'(busy),      32'd0);
      check("reset_done",   32'(done),      32'd0);
      check("reset_result", result,         32'd0);
      check("reset_state",  32'(dbg_state), 32'd0);

      // directed table, issued back-to-back in the done cycle
      foreach (vecs[i]) begin
         start_op(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp);
         wait_done(vecs[i].name);
      end

      // invalid select is ignored
      issue(5'b00001, 32'd10, 32'd2);
      check("add_ignored_busy",  32'(busy),      32'd0);
      check("add_ignored_state", 32'(dbg_state), 32'd0);

      // flush together with start in idle: flush wins
      flush = 1'b1;
      issue(OP_DIVU, 32'd10, 32'd2);
      flush = 1'b0;
      check("flush_start_busy", 32'(busy), 32'd0);

      // flush at E10 of a DIV: no done, result unchanged
      issue(OP_DIV, 32'd1000, 32'd3);
      check("flush_op_busy", 32'(busy), 32'd1);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy_after", 32'(busy), 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      check("flush_no_done", 32'(saw_done), 32'd0);
      check("flush_result_kept", result, last_res);
      start_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3);
      wait_done("divu_9_3");

      // start pulses while busy are ignored
      start_op("busy_ignore", OP_DIVU, 32'd50, 32'd5, 32'd10);
      repeat (5) @(posedge clk);
      #1;
      start  = 1'b1;
      select = OP_REMU;
      data1  = 32'd77;
      data2  = 32'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("busy_ignore");

      // asynchronous reset at E15 of an operation
      issue(OP_DIVU, 32'd12345, 32'd11);
      repeat (14) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("areset_busy",   32'(busy),      32'd0);
      check("areset_done",   32'(done),      32'd0);
      check("areset_result", result,         32'd0);
      check("areset_state",  32'(dbg_state), 32'd0);
      #3;
      reset = 1'b1;
      last_res = '0;
      @(posedge clk);
      #1;

      // randomized operations against the reference model
      for (int i = 0; i < 24; i++) begin
         logic [4:0]  sel;
         logic [31:0] a, b;
         case ($urandom_range(3))
            0: sel = OP_DIV;
            1: sel = OP_DIVU;
            2: sel = OP_REM;
            default: sel = OP_REMU;
         endcase
         a = $urandom;
         case ($urandom_range(3))
            0: b = 32'($urandom_range(15));
            1: b = 32'hFFFF_FFFF - 32'($urandom_range(15));
            default: b = $urandom;
         endcase
         start_op($sformatf("rand%0d", i), sel, a, b, model(sel, a, b));
         wait_done($sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
